// File: rtl/jtframe_romarb_pkg.sv
// Shared types and sizing helpers for the N-channel SDRAM ROM read arbiter.
package jtframe_romarb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWaitAck,
        StWaitData
    } arb_state_e;

    localparam int unsigned MaxCh = 8;

    // Address bits below the 16-bit SDRAM word (or word pair for 32-bit clients)
    function automatic int unsigned bsel_width(int unsigned dw);
        return (dw == 32) ? 2 : 1;
    endfunction

    function automatic int unsigned store_width(int unsigned dw);
        return (dw == 32) ? 32 : 16;
    endfunction

endpackage

// File: rtl/jtframe_romarb_cache.sv
// One-entry tagged read cache for a single arbiter client channel.
module jtframe_romarb_cache
    import jtframe_romarb_pkg::*;
#(
    parameter int unsigned AW = 18,
    parameter int unsigned DW = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           inval,
    input  logic                           wr_en,
    input  logic [AW-bsel_width(DW)-1:0]   wr_tag,
    input  logic [store_width(DW)-1:0]     wr_data,
    input  logic [AW-1:0]                  addr,
    output logic                           hit,
    output logic [DW-1:0]                  dout
);

    localparam int unsigned BSW = bsel_width(DW);
    localparam int unsigned SW  = store_width(DW);
    localparam int unsigned TW  = AW - BSW;

    logic          valid_q, valid_d;
    logic [TW-1:0] tag_q, tag_d;
    logic [SW-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            valid_d = 1'b1;
            tag_d   = wr_tag;
            data_d  = wr_data;
        end
        if (inval) valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign hit = valid_q && (tag_q == addr[AW-1:BSW]);

    if (DW == 8) begin : g_byte
        assign dout = addr[0] ? data_q[15:8] : data_q[7:0];
    end else begin : g_word
        assign dout = data_q;
    end

endmodule

// File: rtl/jtframe_romarb_nch.sv
// N-channel round-robin ROM read arbiter for one SDRAM bank, one cache entry per channel.
// Define JTFRAME_ROMARB_PRIO_EN to give channel 0 strict priority over the round robin.
module jtframe_romarb_nch
    import jtframe_romarb_pkg::*;
#(
    parameter int unsigned      CH   = 4,
    parameter int unsigned      AW   = 18,
    parameter int unsigned      DW   = 8,
    parameter logic [CH*22-1:0] OFFS = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             downloading,
    input  logic [CH-1:0]    ch_cs,
    input  logic [CH*AW-1:0] ch_addr,
    output logic [CH*DW-1:0] ch_data,
    output logic [CH-1:0]    ch_ok,
    output logic [21:0]      ba_addr,
    output logic             ba_rd,
    input  logic             ba_ack,
    input  logic             ba_dst,
    input  logic             ba_dok,
    input  logic             ba_rdy,
    input  logic [15:0]      data_read
);

    localparam int unsigned BSW = bsel_width(DW);
    localparam int unsigned SW  = store_width(DW);
    localparam int unsigned TW  = AW - BSW;
    localparam int unsigned PW  = $clog2(CH);

    arb_state_e    state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d, sel_q, sel_d, pick, rr_idx;
    logic [PW:0]   rr_sum;
    logic          found, done, adv, fill_en;
    logic [21:0]   ba_addr_q, ba_addr_d;
    logic          ba_rd_q, ba_rd_d;
    logic [TW-1:0] tag_lat_q, tag_lat_d;
    logic [15:0]   lo_q, lo_d;
    logic          word_q, word_d, drop_q, drop_d;
    logic [SW-1:0] fill_data;
    logic [CH-1:0] hit, pending;
    logic [21:0]   wa  [CH];
    logic [TW-1:0] tag [CH];

    for (genvar i = 0; i < CH; i++) begin : g_ch
        if (DW == 32) begin : g_wa32
            assign wa[i] = 22'(OFFS[i*22+:22] + {ch_addr[i*AW+2+:AW-2], 1'b0});
        end else begin : g_wa16
            assign wa[i] = 22'(OFFS[i*22+:22] + ch_addr[i*AW+1+:AW-1]);
        end
        assign tag[i]     = ch_addr[i*AW+BSW+:TW];
        assign ch_ok[i]   = ch_cs[i] & hit[i];
        assign pending[i] = ch_cs[i] & ~hit[i] & ~downloading;

        jtframe_romarb_cache #(
            .AW (AW),
            .DW (DW)
        ) u_cache (
            .clk     (clk),
            .rst_n   (rst_n),
            .inval   (downloading),
            .wr_en   (fill_en && (sel_q == PW'(i))),
            .wr_tag  (tag_lat_q),
            .wr_data (fill_data),
            .addr    (ch_addr[i*AW+:AW]),
            .hit     (hit[i]),
            .dout    (ch_data[i*DW+:DW])
        );
    end

    // First pending channel at or after the round-robin pointer
    always_comb begin
        rr_sum = '0;
        rr_idx = '0;
        pick   = '0;
        found  = 1'b0;
        for (int k = 0; k < int'(CH); k++) begin
            rr_sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (rr_sum >= (PW+1)'(CH)) rr_sum = rr_sum - (PW+1)'(CH);
            rr_idx = rr_sum[PW-1:0];
            if (!found && pending[rr_idx]) begin
                found = 1'b1;
                pick  = rr_idx;
            end
        end
`ifdef JTFRAME_ROMARB_PRIO_EN
        if (pending[0]) begin
            found = 1'b1;
            pick  = '0;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ba_addr_d = ba_addr_q;
        ba_rd_d   = ba_rd_q;
        tag_lat_d = tag_lat_q;
        lo_d      = lo_q;
        word_d    = word_q;
        drop_d    = drop_q | downloading;
        done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                ba_rd_d = 1'b0;
                drop_d  = 1'b0;
                if (found) begin
                    sel_d     = pick;
                    ba_addr_d = wa[pick];
                    tag_lat_d = tag[pick];
                    ba_rd_d   = 1'b1;
                    lo_d      = '0;
                    word_d    = 1'b0;
                    state_d   = StWaitAck;
                end
            end
            StWaitAck: begin
                if (ba_ack) begin
                    ba_rd_d = 1'b0;
                    if (ba_rdy) begin
                        done    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StWaitData;
                    end
                end
            end
            StWaitData: begin
                if (ba_dok && !word_q) begin
                    lo_d   = data_read;
                    word_d = 1'b1;
                end
                if (ba_dst) word_d = 1'b0;
                if (ba_rdy) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef JTFRAME_ROMARB_PRIO_EN
    assign adv = done && (sel_q != '0);
`else
    assign adv = done;
`endif

    assign ptr_d   = adv ? ((sel_q == PW'(CH - 1)) ? '0 : sel_q + 1'b1) : ptr_q;
    // A download seen at any point of the transaction voids its fill
    assign fill_en = done & ~drop_d;

    if (SW == 32) begin : g_hi
        logic [15:0] hi_q, hi_d;

        always_comb begin
            hi_d = hi_q;
            if (state_q == StIdle) hi_d = '0;
            else if (state_q == StWaitData && ba_dok && word_q) hi_d = data_read;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) hi_q <= '0;
            else        hi_q <= hi_d;
        end

        assign fill_data = {hi_d, lo_d};
    end else begin : g_lo
        assign fill_data = lo_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            sel_q     <= '0;
            ba_addr_q <= '0;
            ba_rd_q   <= 1'b0;
            tag_lat_q <= '0;
            lo_q      <= '0;
            word_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            ba_addr_q <= ba_addr_d;
            ba_rd_q   <= ba_rd_d;
            tag_lat_q <= tag_lat_d;
            lo_q      <= lo_d;
            word_q    <= word_d;
            drop_q    <= drop_d;
        end
    end

    assign ba_addr = ba_addr_q;
    assign ba_rd   = ba_rd_q;

endmodule
